// File: rtl/axi_lite_master_bw_test.sv
// axi_lite_master_bw_test: AXI4-Lite traffic generator that writes an incrementing pattern, reads it back and times both phases
module axi_lite_master_bw_test #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0,
   parameter int C_NUM_WORDS = 4,
   parameter int C_CYCLE_CNT_WIDTH = 32
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   input  logic                          START,
   output logic                          BUSY,
   output logic                          DONE,
   output logic                          ERROR,
   output logic [15:0]                   ERR_CNT,
   output logic [C_CYCLE_CNT_WIDTH-1:0]  WR_CYCLES,
   output logic [C_CYCLE_CNT_WIDTH-1:0]  RD_CYCLES,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN} state_t;
   state_t state, state_nx;
   logic [8:0] idx;
   logic aw_done, w_done, done_r, error_r, last;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, err_inc, in_wr, in_rd;
   logic [15:0] err_cnt;
   logic [C_CYCLE_CNT_WIDTH-1:0] wr_cyc, rd_cyc;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] word;

   assign addr  = C_M_TARGET_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
   assign word  = C_M_AXI_DATA_WIDTH'(idx + 9'd1);
   assign last  = idx == 9'(C_NUM_WORDS - 1);
   assign in_wr = state == WR_REQ || state == WR_RESP;
   assign in_rd = state == RD_REQ || state == RD_RESP;

   assign M_AXI_AWADDR  = addr;
   assign M_AXI_ARADDR  = addr;
   assign M_AXI_WDATA   = word;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_AWVALID = state == WR_REQ && !aw_done;
   assign M_AXI_WVALID  = state == WR_REQ && !w_done;
   assign M_AXI_BREADY  = state == WR_RESP;
   assign M_AXI_ARVALID = state == RD_REQ;
   assign M_AXI_RREADY  = state == RD_RESP;

   assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
   assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;
   assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
   assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;
   assign err_inc = (b_hs && M_AXI_BRESP != 2'b00) ||
                    (r_hs && (M_AXI_RDATA != word || M_AXI_RRESP != 2'b00));

   assign BUSY      = state != IDLE;
   assign DONE      = done_r;
   assign ERROR     = error_r;
   assign ERR_CNT   = err_cnt;
   assign WR_CYCLES = wr_cyc;
   assign RD_CYCLES = rd_cyc;

   // state register
   always_ff @(posedge M_AXI_ACLK)
      state <= M_AXI_ARESET ? IDLE : state_nx;

   // next-state: one outstanding transaction, write phase then read-back phase
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = START ? WR_REQ : IDLE;
         WR_REQ:  state_nx = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP : WR_REQ;
         WR_RESP: state_nx = b_hs ? (last ? RD_REQ : WR_REQ) : WR_RESP;
         RD_REQ:  state_nx = ar_hs ? RD_RESP : RD_REQ;
         RD_RESP: state_nx = r_hs ? (last ? FIN : RD_REQ) : RD_RESP;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // word index, per-channel handshake flags, status flags and saturating counters
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         idx     <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
         err_cnt <= '0;
         wr_cyc  <= '0;
         rd_cyc  <= '0;
      end else begin
         aw_done <= state == WR_REQ && (aw_done || aw_hs);
         w_done  <= state == WR_REQ && (w_done || w_hs);
         if (b_hs || r_hs)
            idx <= last ? '0 : idx + 9'd1;
         if (state == IDLE && START) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            err_cnt <= '0;
            wr_cyc  <= '0;
            rd_cyc  <= '0;
         end else begin
            if (err_inc && err_cnt != '1)
               err_cnt <= err_cnt + 16'd1;
            if (in_wr && wr_cyc != '1)
               wr_cyc <= wr_cyc + C_CYCLE_CNT_WIDTH'(1);
            if (in_rd && rd_cyc != '1)
               rd_cyc <= rd_cyc + C_CYCLE_CNT_WIDTH'(1);
         end
         if (state == FIN) begin
            done_r  <= 1'b1;
            error_r <= err_cnt != '0;
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_master_bw_test.sv
// tb_axi_lite_master_bw_test: directed tests against a four-register AXI4-Lite responder
module tb_axi_lite_master_bw_test;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, busy, done, error;
   logic [15:0] err_cnt;
   logic [31:0] wr_cycles, rd_cycles;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;

   int checks = 0, errors = 0;
   logic [31:0] mem [4];
   logic [31:0] wr_addr_log [4];
   logic [31:0] wr_data_log [4];
   int stall_aw = 0, wr_n = 0, rd_n = 0, aw_cyc = 0, w_cyc = 0, br_cyc = 0;
   logic bad_rd_en = 1'b0, err_en = 1'b0;

   axi_lite_master_bw_test dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .START(start), .BUSY(busy), .DONE(done),
      .ERROR(error), .ERR_CNT(err_cnt), .WR_CYCLES(wr_cycles), .RD_CYCLES(rd_cycles),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // responder: samples handshakes mid-cycle, answers one cycle after the request handshake
   initial begin
      logic rs, aw_h, w_h, b_h, ar_h, r_h, dec, have_aw, have_w;
      logic [31:0] cap_aw, cap_w, cap_ar;
      have_aw = 0; have_w = 0; cap_aw = 0; cap_w = 0; cap_ar = 0;
      awready = 1; wready = 1; arready = 1; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      for (int i = 0; i < 4; i++) mem[i] = 0;
      forever begin
         @(negedge clk);
         rs = rst;
         aw_h = awvalid & awready; w_h = wvalid & wready; b_h = bvalid & bready;
         ar_h = arvalid & arready; r_h = rvalid & rready;
         dec = awvalid && stall_aw > 0;
         aw_cyc += int'(awvalid); w_cyc += int'(wvalid); br_cyc += int'(bready);
         if (aw_h) cap_aw = awaddr;
         if (w_h) cap_w = wdata;
         if (ar_h) cap_ar = araddr;
         @(posedge clk); #1;
         if (rs) begin
            bvalid = 0; rvalid = 0; have_aw = 0; have_w = 0;
         end else begin
            if (dec) stall_aw--;
            awready = stall_aw == 0;
            if (b_h) bvalid = 0;
            if (r_h) rvalid = 0;
            if (aw_h) have_aw = 1;
            if (w_h) have_w = 1;
            if (have_aw && have_w) begin
               mem[cap_aw[3:2]] = cap_w;
               if (wr_n < 4) begin
                  wr_addr_log[wr_n] = cap_aw;
                  wr_data_log[wr_n] = cap_w;
               end
               wr_n++;
               bresp = (err_en && cap_aw == 32'h4) ? 2'b10 : 2'b00;
               bvalid = 1; have_aw = 0; have_w = 0;
            end
            if (ar_h) begin
               rdata = mem[cap_ar[3:2]];
               rresp = 2'b00;
               if (bad_rd_en && cap_ar == 32'h8) rdata = 32'hDEAD;
               if (err_en && cap_ar == 32'hC) begin rresp = 2'b10; rdata = ~rdata; end
               rvalid = 1; rd_n++;
            end
         end
      end
   end

   task automatic clear_stats();
      wr_n = 0; rd_n = 0; aw_cyc = 0; w_cyc = 0; br_cyc = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (done) return;
         @(posedge clk); #1;
      end
      check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic run_test(input string tag);
      clear_stats();
      pulse_start();
      wait_done(tag);
   endtask

   initial begin
      rst = 1; start = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_cnt, 0);
      check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("rst_prot_strb", {awprot, arprot, wstrb}, 32'h00F);
      rst = 0;

      run_test("basic");
      check("basic_done", done, 1);
      check("basic_error", error, 0);
      check("basic_errcnt", err_cnt, 0);
      check("basic_wrcyc", wr_cycles, 8);
      check("basic_rdcyc", rd_cycles, 8);
      for (int i = 0; i < 4; i++) begin
         check("basic_waddr", wr_addr_log[i], 32'(4 * i));
         check("basic_wdata", wr_data_log[i], 32'(i + 1));
      end
      check("basic_reads", rd_n, 4);

      stall_aw = 3;
      run_test("stall");
      check("stall_wrcyc", wr_cycles, 11);
      check("stall_rdcyc", rd_cycles, 8);
      check("stall_aw_cycles", aw_cyc, 7);
      check("stall_w_cycles", w_cyc, 4);
      check("stall_bready_cycles", br_cyc, 4);
      check("stall_errcnt", err_cnt, 0);

      bad_rd_en = 1;
      run_test("baddata");
      bad_rd_en = 0;
      check("baddata_errcnt", err_cnt, 1);
      check("baddata_error", error, 1);
      check("baddata_done", done, 1);

      err_en = 1;
      run_test("slverr");
      err_en = 0;
      check("slverr_errcnt", err_cnt, 2);
      check("slverr_error", error, 1);

      clear_stats();
      pulse_start();
      check("restart_done", done, 0);
      check("restart_errcnt", err_cnt, 0);
      check("restart_wrcyc", wr_cycles, 0);
      check("restart_busy", busy, 1);
      begin
         int n;
         n = 0;
         while (!arvalid && n < 100) begin @(posedge clk); #1; n++; end
         check("reads_reached", arvalid, 1);
      end
      pulse_start();
      wait_done("repulse");
      repeat (3) @(posedge clk);
      #1;
      check("repulse_busy", busy, 0);
      check("repulse_writes", wr_n, 4);
      check("repulse_reads", rd_n, 4);
      check("repulse_wrcyc", wr_cycles, 8);
      check("repulse_rdcyc", rd_cycles, 8);

      clear_stats();
      pulse_start();
      check("midrst_awvalid", awvalid, 1);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      check("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("midrst_busy", busy, 0);
      check("midrst_counters", {err_cnt, wr_cycles[7:0], rd_cycles[7:0]}, 0);
      check("midrst_done", done, 0);
      run_test("postrst");
      check("postrst_done", done, 1);
      check("postrst_errcnt", err_cnt, 0);
      check("postrst_wrcyc", wr_cycles, 8);
      check("postrst_rdcyc", rd_cycles, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_lite_master_bw_test.md
Name: axi_lite_master_bw_test

Overview:
- AXI4-Lite initiator (traffic generator) for the bus bandwidth test; it is the master-side counterpart of axi_lite_slave.
- On a START pulse it issues C_NUM_WORDS sequential single-beat writes of an incrementing pattern starting at C_M_TARGET_BASE_ADDR, then reads every word back and compares it.
- It reports separate write-phase and read-phase cycle counts and an error count to the PS/status logic.
- It keeps one transaction outstanding at a time.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: AxADDR width.
- C_M_AXI_DATA_WIDTH, 32: WDATA/RDATA width; only 32 is supported.
- C_M_TARGET_BASE_ADDR, 32'h0000_0000: address of word 0.
- C_NUM_WORDS, 4: words per test, range 1..256.
- C_CYCLE_CNT_WIDTH, 32: width of the cycle counters.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse that begins a test.
- BUSY  out  1  high while a test runs.
- DONE  out  1  sticky; set at test end, cleared by the next accepted START.
- ERROR  out  1  sticky; high when ERR_CNT != 0 at end of test.
- ERR_CNT  out  16  count of mismatches plus non-OKAY responses.
- WR_CYCLES  out  C_CYCLE_CNT_WIDTH  cycles spent in the write phase.
- RD_CYCLES  out  C_CYCLE_CNT_WIDTH  cycles spent in the read phase.
- M_AXI_AWADDR out ADDR; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset (sampled on the M_AXI_ACLK edge) applies in any state, including mid-transaction. On the next edge:
  - state = IDLE;
  - all VALID/READY outputs = 0;
  - BUSY = DONE = ERROR = 0;
  - ERR_CNT, WR_CYCLES, RD_CYCLES = 0;
  - word index idx = 0.
- Constant outputs: AxPROT = 3'b000; WSTRB = 4'hF.
- Addressing and data pattern:
  - address for word idx = C_M_TARGET_BASE_ADDR + 4*idx;
  - write data = idx + 1, so word 0 = 0x00000001;
  - expected read data = idx + 1.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN.
- IDLE:
  - START=1 → WR_REQ;
  - on entry to WR_REQ, clear ERR_CNT, WR_CYCLES, RD_CYCLES, DONE and ERROR, and set BUSY=1.
  - START while BUSY=1 is ignored.
- WR_REQ:
  - AWVALID and WVALID rise together on entry;
  - each drops on the cycle after its own handshake (VALID & READY sampled high);
  - AWADDR and WDATA stay stable while the corresponding VALID is high;
  - once both handshakes have completed (same or different cycles) → WR_RESP with BREADY=1.
- WR_RESP, on a BVALID & BREADY handshake:
  - BREADY drops;
  - BRESP != 2'b00 → ERR_CNT++;
  - if idx == C_NUM_WORDS-1: idx = 0 → RD_REQ;
  - else idx++ → WR_REQ, with new AW/W valids asserted on the next cycle.
- RD_REQ: ARVALID = 1 until the ARREADY handshake, then → RD_RESP with RREADY=1.
- RD_RESP, on an RVALID & RREADY handshake:
  - RREADY drops;
  - ERR_CNT++ if RDATA != idx+1 OR RRESP != 2'b00 (one increment per beat, never two);
  - the last word → FIN; otherwise idx++ → RD_REQ.
- FIN: BUSY=0, DONE=1, ERROR = (ERR_CNT != 0); next state IDLE.
- VALID never waits on READY. No VALID is deasserted without a handshake except by reset.
- Cycle counters:
  - WR_CYCLES increments on every clock edge where state ∈ {WR_REQ, WR_RESP};
  - RD_CYCLES increments on every edge where state ∈ {RD_REQ, RD_RESP};
  - both saturate at all-ones;
  - ERR_CNT saturates at 16'hFFFF.
- Latency, with the reference responder (all READY=1, response asserted the cycle after the address/data handshake): 2 cycles per write and 2 per read, so WR_CYCLES = RD_CYCLES = 2*C_NUM_WORDS.
- Boundaries:
  - C_NUM_WORDS=1: exactly one write and one read;
  - an early BVALID/RVALID (before the request handshake) is not accepted, because BREADY/RREADY are still 0.

Test Plan:
- Reference responder (4 registers at 0x0–0xC), START pulse → writes 1,2,3,4 to 0x0,0x4,0x8,0xC, reads back 1..4; DONE=1, ERROR=0, ERR_CNT=0, WR_CYCLES=8, RD_CYCLES=8.
- AWREADY held low for 3 cycles, WREADY=1 → WVALID high 1 cycle, AWVALID high 4 cycles, BREADY not asserted until both handshakes complete; WR_CYCLES = 8+3 = 11.
- Responder returns RDATA=0xDEAD for address 0x8 → ERR_CNT=1, ERROR=1, DONE=1.
- Responder returns BRESP=SLVERR on the write to 0x4 and RRESP=SLVERR with corrupted data on the read of 0xC → ERR_CNT=2 (one per beat).
- START re-pulsed during the read phase → ignored, one test completes; a new START after DONE → counters clear on the next cycle, DONE falls.
- M_AXI_ARESET asserted for 1 cycle while AWVALID is high → next edge: all VALID/READY=0, BUSY=0, counters=0; a subsequent START runs a clean test with the first-test results (ERR_CNT=0, WR_CYCLES=8).
